// File: rtl/tdm_demux4_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux4_pkg
//   Shared definitions for the four-channel TDM demultiplexer.
//   - state_t        : framing state (HUNT = searching for sync, LOCKED = in frame)
//   - SLOT_A..SLOT_D : slot indices for channels a..d
//   - NUM_SLOTS      : number of channels (slots) per frame
// -----------------------------------------------------------------------------
package tdm_demux4_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NUM_SLOTS = 4;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

endpackage : tdm_demux4_pkg

// File: rtl/tdm_slot_ctr.sv
// -----------------------------------------------------------------------------
// tdm_slot_ctr
//   Two-bit slot counter for the TDM demultiplexer.
//   The counter holds the index of the next expected slot.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high; slot returns to SLOT_A
//   clear    in   force slot back to SLOT_A (framing lost)
//   load     in   sync beat accepted as slot 0; next expected slot is SLOT_B
//   advance  in   ordinary beat accepted in the current slot
//   slot     out  index of the next expected slot
//   wrap     out  the beat being accepted is the last slot of the frame
//
// Priority: clear > load > advance.
// -----------------------------------------------------------------------------
module tdm_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       advance,
  output logic [1:0] slot,
  output logic       wrap
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= SLOT_A;
    end else if (clear) begin
      slot <= SLOT_A;
    end else if (load) begin
      slot <= SLOT_B;
    end else if (advance) begin
      // Two-bit add wraps SLOT_D back to SLOT_A, matching NUM_SLOTS = 4.
      slot <= slot + 2'd1;
    end
  end

  // Only an ordinary beat can close a frame; a sync beat always restarts one.
  assign wrap = advance && (slot == SLOT_D);

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//   Receive-side TDM demultiplexer: splits a four-slot time-division stream
//   (slot 0 flagged by sync) back onto four registered channel outputs.
//
// Parameters:
//   WIDTH        sample width of din and of each channel output
//   REQUIRE_SYNC 1: every frame must start with sync on slot 0
//                0: sync is only needed to acquire lock
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high; clears all state at once
//   din          in   sample for the current slot
//   din_valid    in   din carries a beat this cycle (otherwise ignored)
//   sync         in   beat is slot 0 (qualified by din_valid)
//   a, b, c, d   out  channel samples of the last complete frame
//   frame_valid  out  one-cycle pulse: a..d were updated this cycle
//   locked       out  high while in LOCKED state
//   sync_err     out  one-cycle pulse on a framing violation
//   slot         out  index of the next expected slot
//
// Pipeline: a beat is captured into the shadow registers on the edge it is
// sampled; frame completion and framing errors are flagged on that edge and
// turned into outputs on the following edge.  Because each beat produces at
// most one of the two flags, frame_valid and sync_err can never coincide.
// -----------------------------------------------------------------------------
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter bit REQUIRE_SYNC = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [1:0]       slot
);

  state_t           state;
  logic [WIDTH-1:0] shadow [NUM_SLOTS];
  logic [1:0]       slot_q;

  // Beat decode
  logic ctr_clear;    // slot-0 beat without sync in strict mode: drop lock
  logic ctr_load;     // sync beat: (re)start a frame at slot 0
  logic ctr_advance;  // ordinary in-frame beat
  logic ctr_wrap;     // ordinary beat in the last slot
  logic violation;    // early sync or missing sync

  // Stage between capture and commit
  logic commit_pend;
  logic err_pend;

  // ---------------------------------------------------------------------------
  // Beat classification
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    ctr_clear   = 1'b0;
    ctr_load    = 1'b0;
    ctr_advance = 1'b0;
    violation   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          ctr_load = sync;
        end
        LOCKED: begin
          if (sync) begin
            // A sync always starts a new frame; outside slot 0 the partial
            // frame is abandoned and reported.
            ctr_load  = 1'b1;
            violation = (slot_q != SLOT_A);
          end else if (REQUIRE_SYNC && (slot_q == SLOT_A)) begin
            ctr_clear = 1'b1;
            violation = 1'b1;
          end else begin
            ctr_advance = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear),
    .load    (ctr_load),
    .advance (ctr_advance),
    .slot    (slot_q),
    .wrap    (ctr_wrap)
  );

  assign slot   = slot_q;
  assign locked = (state == LOCKED);

  // ---------------------------------------------------------------------------
  // Capture stage: framing state and shadow registers
  // ---------------------------------------------------------------------------
  // NOTE: the four shadow registers are reset because a reset must leave no
  // trace of a partial frame; a deeper buffer would normally be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      commit_pend <= 1'b0;
      err_pend    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      commit_pend <= ctr_wrap;
      err_pend    <= violation;

      if (ctr_load) begin
        shadow[SLOT_A] <= din;
        state          <= LOCKED;
      end else if (ctr_advance) begin
        shadow[slot_q] <= din;
      end else if (ctr_clear) begin
        state <= HUNT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit stage: outputs update together one edge after the last beat.
  // A back-to-back slot-0 beat may overwrite shadow[0] on this same edge; the
  // commit still picks up the completed frame's value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= commit_pend;
      sync_err    <= err_pend;
      if (commit_pend) begin
        a <= shadow[SLOT_A];
        b <= shadow[SLOT_B];
        c <= shadow[SLOT_C];
        d <= shadow[SLOT_D];
      end
    end
  end

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4
//   Two instances share one input stream: u_req (REQUIRE_SYNC = 1) and
//   u_lax (REQUIRE_SYNC = 0).  Every cycle both are compared with a frame-level
//   reference model (list of collected samples per frame, lock flag, pending
//   output event one edge later).  A vector table and short directed sequences
//   cover the listed scenarios.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;

  logic [W-1:0] a0, b0, c0, d0, a1, b1, c1, d1;
  logic         fv0, fv1, lk0, lk1, se0, se1;
  logic [1:0]   sl0, sl1;

  tdm_demux4 #(.WIDTH(W), .REQUIRE_SYNC(1'b1)) u_req (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .a(a0), .b(b0), .c(c0), .d(d0), .frame_valid(fv0), .locked(lk0),
    .sync_err(se0), .slot(sl0)
  );

  tdm_demux4 #(.WIDTH(W), .REQUIRE_SYNC(1'b0)) u_lax (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
    .a(a1), .b(b1), .c(c1), .d(d1), .frame_valid(fv1), .locked(lk1),
    .sync_err(se1), .slot(sl1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, index 0 = strict instance, 1 = lax instance
  // ---------------------------------------------------------------------------
  bit           m_locked [2];
  int           m_cnt    [2];        // samples collected in the current frame
  logic [W-1:0] m_fr     [2][4];
  logic [W-1:0] m_out    [2][4];
  bit           m_fv     [2];
  bit           m_err    [2];
  bit           p_commit [2];
  bit           p_err    [2];
  logic [W-1:0] p_fr     [2][4];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_locked[i] = 1'b0;
      m_cnt[i]    = 0;
      m_fv[i]     = 1'b0;
      m_err[i]    = 1'b0;
      p_commit[i] = 1'b0;
      p_err[i]    = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_out[i][k] = '0;
        m_fr[i][k]  = '0;
      end
    end
  endtask

  task automatic model_edge(input bit v, input bit s, input logic [W-1:0] x);
    for (int i = 0; i < 2; i++) begin
      m_fv[i]  = p_commit[i];
      m_err[i] = p_err[i];
      if (p_commit[i]) for (int k = 0; k < 4; k++) m_out[i][k] = p_fr[i][k];
      p_commit[i] = 1'b0;
      p_err[i]    = 1'b0;
      if (v) begin
        if (!m_locked[i]) begin
          if (s) begin
            m_locked[i] = 1'b1;
            m_fr[i][0]  = x;
            m_cnt[i]    = 1;
          end
        end else if (s) begin
          if (m_cnt[i] != 0) p_err[i] = 1'b1;
          m_fr[i][0] = x;
          m_cnt[i]   = 1;
        end else if (m_cnt[i] == 0 && i == 0) begin
          p_err[i]    = 1'b1;
          m_locked[i] = 1'b0;
        end else begin
          m_fr[i][m_cnt[i]] = x;
          m_cnt[i]++;
          if (m_cnt[i] == 4) begin
            p_commit[i] = 1'b1;
            for (int k = 0; k < 4; k++) p_fr[i][k] = m_fr[i][k];
            m_cnt[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic [W-1:0] o [4];
      logic         fv, se, lk;
      logic [1:0]   sl;
      if (i == 0) begin
        o[0] = a0; o[1] = b0; o[2] = c0; o[3] = d0;
        fv = fv0; se = se0; lk = lk0; sl = sl0;
      end else begin
        o[0] = a1; o[1] = b1; o[2] = c1; o[3] = d1;
        fv = fv1; se = se1; lk = lk1; sl = sl1;
      end
      for (int k = 0; k < 4; k++)
        check($sformatf("%s dut%0d ch%0d", tag, i, k), 32'(o[k]), 32'(m_out[i][k]));
      check($sformatf("%s dut%0d frame_valid", tag, i), 32'(fv), 32'(m_fv[i]));
      check($sformatf("%s dut%0d sync_err", tag, i), 32'(se), 32'(m_err[i]));
      check($sformatf("%s dut%0d locked", tag, i), 32'(lk), 32'(m_locked[i]));
      check($sformatf("%s dut%0d slot", tag, i), 32'(sl), 32'(m_cnt[i]));
    end
  endtask

  // One clock: drive, let the edge happen, sample 1 ns later, compare.
  task automatic step(input string tag, input bit v, input bit s, input logic [W-1:0] x);
    din_valid = v;
    sync      = s;
    din       = x;
    @(posedge clk);
    #1;
    model_edge(v, s, x);
    compare_model(tag);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table (strict instance): inputs and expected outputs after the edge
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         v;
    bit         s;
    logic [3:0] x;
    bit         fv;
    logic [3:0] ea, eb, ec, ed;
    bit         lk;
    logic [1:0] sl;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  function automatic vec_t mk(bit v, bit s, logic [3:0] x, bit fv,
                              logic [3:0] ea, logic [3:0] eb, logic [3:0] ec,
                              logic [3:0] ed, bit lk, logic [1:0] sl);
    vec_t r;
    r.v = v; r.s = s; r.x = x; r.fv = fv;
    r.ea = ea; r.eb = eb; r.ec = ec; r.ed = ed; r.lk = lk; r.sl = sl;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             v  s  x     fv a     b     c     d     lk sl
    tbl[0]  = mk(1, 1, 4'h1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2'd1);
    tbl[1]  = mk(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2'd2);
    tbl[2]  = mk(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2'd3);
    tbl[3]  = mk(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2'd0);
    tbl[4]  = mk(1, 1, 4'hA, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1, 2'd1);
    tbl[5]  = mk(1, 0, 4'h5, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1, 2'd2);
    tbl[6]  = mk(1, 0, 4'h3, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1, 2'd3);
    tbl[7]  = mk(1, 0, 4'hC, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1, 2'd0);
    tbl[8]  = mk(1, 1, 4'h1, 1, 4'hA, 4'h5, 4'h3, 4'hC, 1, 2'd1);
    tbl[9]  = mk(1, 0, 4'h2, 0, 4'hA, 4'h5, 4'h3, 4'hC, 1, 2'd2);
    tbl[10] = mk(1, 0, 4'h4, 0, 4'hA, 4'h5, 4'h3, 4'hC, 1, 2'd3);
    tbl[11] = mk(1, 0, 4'h8, 0, 4'hA, 4'h5, 4'h3, 4'hC, 1, 2'd0);
    tbl[12] = mk(0, 0, 4'h0, 1, 4'h1, 4'h2, 4'h4, 4'h8, 1, 2'd0);
    tbl[13] = mk(0, 1, 4'hF, 0, 4'h1, 4'h2, 4'h4, 4'h8, 1, 2'd0);

    // Reset values
    apply_reset();
    compare_model("reset");
    check("reset a", 32'(a0), 32'h0);
    check("reset locked", 32'(lk0), 32'h0);
    check("reset slot", 32'(sl0), 32'h0);

    // Continuous frames from the table
    for (int n = 0; n < NV; n++) begin
      step($sformatf("tbl%0d", n), tbl[n].v, tbl[n].s, tbl[n].x);
      check($sformatf("tbl%0d frame_valid", n), 32'(fv0), 32'(tbl[n].fv));
      check($sformatf("tbl%0d a", n), 32'(a0), 32'(tbl[n].ea));
      check($sformatf("tbl%0d b", n), 32'(b0), 32'(tbl[n].eb));
      check($sformatf("tbl%0d c", n), 32'(c0), 32'(tbl[n].ec));
      check($sformatf("tbl%0d d", n), 32'(d0), 32'(tbl[n].ed));
      check($sformatf("tbl%0d locked", n), 32'(lk0), 32'(tbl[n].lk));
      check($sformatf("tbl%0d slot", n), 32'(sl0), 32'(tbl[n].sl));
      check($sformatf("tbl%0d sync_err", n), 32'(se0), 32'h0);
    end

    // HUNT: beats without sync are discarded
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      step("hunt", 1'b1, 1'b0, 4'hF);
      check("hunt locked", 32'(lk0), 32'h0);
      check("hunt slot", 32'(sl0), 32'h0);
    end
    step("hunt_sync", 1'b1, 1'b1, 4'h7);
    check("hunt_sync slot", 32'(sl0), 32'h1);
    step("hunt_b1", 1'b1, 1'b0, 4'h1);
    step("hunt_b2", 1'b1, 1'b0, 4'h2);
    step("hunt_b3", 1'b1, 1'b0, 4'h3);
    check("hunt frame not yet", 32'(fv0), 32'h0);
    step("hunt_done", 1'b0, 1'b0, 4'h0);
    check("hunt frame_valid", 32'(fv0), 32'h1);
    check("hunt a", 32'(a0), 32'h7);
    check("hunt d", 32'(d0), 32'h3);

    // Early sync on slot 2
    step("es0", 1'b1, 1'b1, 4'h1);
    step("es1", 1'b1, 1'b0, 4'h2);
    check("early slot before", 32'(sl0), 32'h2);
    step("es_sync", 1'b1, 1'b1, 4'h9);
    check("early slot restart", 32'(sl0), 32'h1);
    step("es2", 1'b1, 1'b0, 4'h8);
    check("early sync_err", 32'(se0), 32'h1);
    check("early no frame", 32'(fv0), 32'h0);
    check("early a held", 32'(a0), 32'h7);
    step("es3", 1'b1, 1'b0, 4'h7);
    check("early sync_err one cycle", 32'(se0), 32'h0);
    step("es4", 1'b1, 1'b0, 4'h6);
    step("es_done", 1'b0, 1'b0, 4'h0);
    check("early new frame_valid", 32'(fv0), 32'h1);
    check("early new a", 32'(a0), 32'h9);
    check("early new d", 32'(d0), 32'h6);

    // Slot-0 beat without sync: strict drops lock, lax accepts
    step("ns", 1'b1, 1'b0, 4'h3);
    check("nosync strict locked", 32'(lk0), 32'h0);
    check("nosync strict slot", 32'(sl0), 32'h0);
    check("nosync lax slot", 32'(sl1), 32'h1);
    step("ns1", 1'b1, 1'b0, 4'h4);
    check("nosync strict sync_err", 32'(se0), 32'h1);
    check("nosync lax sync_err", 32'(se1), 32'h0);
    step("ns2", 1'b1, 1'b0, 4'h5);
    step("ns3", 1'b1, 1'b0, 4'h6);
    step("ns_done", 1'b0, 1'b0, 4'h0);
    check("nosync lax frame_valid", 32'(fv1), 32'h1);
    check("nosync lax a", 32'(a1), 32'h3);
    check("nosync lax d", 32'(d1), 32'h6);
    check("nosync strict no frame", 32'(fv0), 32'h0);

    // Gaps inside a frame, then asynchronous reset at slot 2
    step("gap_sync", 1'b1, 1'b1, 4'h5);
    step("gap0", 1'b0, 1'b0, 4'hE);
    check("gap slot hold", 32'(sl0), 32'h1);
    step("gap1", 1'b1, 1'b0, 4'h6);
    step("gap2", 1'b0, 1'b1, 4'hD);
    check("gap slot hold 2", 32'(sl0), 32'h2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_model("async_reset");
    check("async a cleared", 32'(a1), 32'h0);
    check("async locked cleared", 32'(lk0), 32'h0);
    check("async slot cleared", 32'(sl0), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset", 1'b1, 1'b0, 4'h2);
    check("post reset needs sync", 32'(lk1), 32'h0);

    // Randomised stream against the model
    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
           W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_tdm_demux4
